// File: rtl/digit_serial_adder_pkg.sv
// Shared types and constants for the digit-serial adder.
package dsa_pkg;
  localparam int DIGIT_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/digit_serial_adder_cla4bit.sv
// 4-bit carry-lookahead adder cell used as the per-digit adder.
module CLA4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: one 4-bit digit per cycle, LSD first, valid/ready on both sides.
// Optional subtract mode enabled by defining DIGIT_SERIAL_ADDER_SUB_EN.
import dsa_pkg::*;

module digit_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  state_t              state;
  logic [WIDTH-1:0]    a_sr, b_sr;
  logic                carry;
  logic [CNT_W-1:0]    cnt;
  logic [DIGIT_W-1:0]  d_b, d_sum;
  logic                d_cout;
  logic                init_carry;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  logic sub_r;
  // Subtraction feeds the inverted b digit; the +1 comes from the seeded carry.
  assign d_b        = sub_r ? ~b_sr[DIGIT_W-1:0] : b_sr[DIGIT_W-1:0];
  assign init_carry = sub ? 1'b1 : cin;
`else
  assign d_b        = b_sr[DIGIT_W-1:0];
  assign init_carry = cin;
`endif

  CLA4bit u_cla (
    .a    (a_sr[DIGIT_W-1:0]),
    .b    (d_b),
    .cin  (carry),
    .sum  (d_sum),
    .cout (d_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      sub_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          a_sr     <= a;
          b_sr     <= b;
          carry    <= init_carry;
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
          sub_r    <= sub;
`endif
        end
        RUN: begin
          // Result digits enter at the MSB end so the first digit lands at bit 0.
          sum   <= WIDTH'({d_sum, sum} >> DIGIT_W);
          carry <= d_cout;
          a_sr  <= a_sr >> DIGIT_W;
          b_sr  <= b_sr >> DIGIT_W;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIGITS - 1)) begin
            cout      <= d_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Randomized and directed checks of digit_serial_adder against an arithmetic model.
module tb_digit_serial_adder;
  localparam int W   = 16;
  localparam int DIG = W / 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [W-1:0]  a = '0, b = '0;
  logic          in_ready, out_valid, cout;
  logic [W-1:0]  sum;

  logic          iv4 = 1'b0, or4 = 1'b0, cin4 = 1'b0;
  logic [3:0]    a4 = '0, b4 = '0;
  logic          ir4, ov4, cout4;
  logic [3:0]    sum4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  digit_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(ov4), .out_ready(or4),
    .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full transaction; junk=1 keeps in_valid high with changing operands while busy.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input int hold, input bit junk);
    logic [W:0] exp;
    int n;
    exp = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    n = 0;
    while (!in_ready && n < 50) begin cyc(); n++; end
    chk("ready_wait", in_ready, 1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    cyc();
    if (!junk) in_valid = 1'b0;
    for (int k = 1; k <= DIG; k++) begin
      if (junk) begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
      chk("busy_ready", in_ready, 0);
      cyc();
      chk("latency", out_valid, (k == DIG) ? 1 : 0);
    end
    chk("sum", sum, exp[W-1:0]);
    chk("cout", cout, exp[W]);
    for (int h = 0; h < hold; h++) begin
      cyc();
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_data", {cout, sum}, exp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_ready", in_ready, 1);
  endtask

  initial begin
    int first, second;
    logic [4:0] e4;
    // reset state
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", {cout, sum}, 0);
    chk("rst_ready4", ir4, 1);
    chk("rst_sum4", {cout4, sum4}, 0);

    // directed cases
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op(16'h1234, 16'h4321, 1'b1, 5, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b0, 0, 1'b0);

    // reset in the second RUN cycle discards the operation
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_sum", {cout, sum}, 0);
    for (int i = 0; i < DIG + 2; i++) begin
      chk("midrst_novalid", out_valid, 0);
      cyc();
    end
    run_op(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0);

    // operands change while busy: only accepted values matter
    run_op(16'h8001, 16'h7FFF, 1'b0, 2, 1'b1);

    // random traffic
    for (int i = 0; i < 25; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    // back-to-back throughput
    a = 16'h0102; b = 16'h0304; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    first = -1; second = -1;
    for (int t = 0; t < 40 && second < 0; t++) begin
      cyc();
      if (out_valid) begin
        if (first < 0) first = t; else second = t;
      end
    end
    chk("b2b_seen", (second >= 0) ? 1 : 0, 1);
    chk("b2b_period", second - first, DIG + 2);
    chk("b2b_sum", {cout, sum}, 17'h00406);
    in_valid = 1'b0;
    cyc(); cyc();
    out_ready = 1'b0;

    // WIDTH=4 boundary: single-digit latency
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; end
      else begin a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); end
      e4 = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
      chk("w4_ready", ir4, 1);
      iv4 = 1'b1;
      cyc();
      iv4 = 1'b0;
      chk("w4_run", ov4, 0);
      cyc();
      chk("w4_valid", ov4, 1);
      chk("w4_result", {cout4, sum4}, e4);
      or4 = 1'b1;
      cyc();
      or4 = 1'b0;
      chk("w4_release", ov4, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand width in bits; legal values are multiples of 4 and at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operands presented.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: unsigned operands.
REQ-007 SHALL have port cin, input, 1 bit: carry-in.
REQ-008 SHALL have port out_valid, output, 1 bit: result available.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port sum, output, WIDTH bits: registered result.
REQ-011 SHALL have port cout, output, 1 bit: registered carry-out.

Function
REQ-012 SHALL compute {cout,sum} = a + b + cin modulo 2^(WIDTH+1), one 4-bit digit per cycle, least significant digit first; DIGITS = WIDTH/4.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE SHALL drive in_ready=1, out_valid=0; on in_valid&in_ready SHALL latch a, b into shift registers, cin into the carry register, clear the digit counter, and go to RUN.
REQ-015 RUN SHALL, each cycle, add the low operand digits plus the carry register, shift the 4-bit digit result into sum from the MSB end, update the carry register, shift the operands right by 4, and increment the counter.
REQ-016 RUN SHALL go to DONE on the cycle where counter == DIGITS-1; cout SHALL take the final carry at that edge.
REQ-017 Latency SHALL be exactly DIGITS cycles: with the accept edge at E0, out_valid rises at edge E0+DIGITS.
REQ-018 DONE SHALL drive out_valid=1, in_ready=0; sum and cout SHALL be held stable while out_valid&!out_ready.
REQ-019 DONE with out_ready=1 SHALL go to IDLE; in_ready SHALL be 0 during that cycle, and a new accept SHALL occur no earlier than the following cycle.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored, with no latching and no side effect.
REQ-021 Back-to-back throughput SHALL be one result per DIGITS+2 cycles when in_valid and out_ready are both held high.
REQ-022 The counter SHALL be ceil(log2(DIGITS+1)) bits wide, and a counter wrap SHALL never occur.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE and clear sum, cout, carry register, counter and operand registers to 0; out_valid=0 and in_ready=1 the cycle after.
REQ-024 rst SHALL take priority over every handshake; a reset in RUN or DONE SHALL discard the operation with no out_valid pulse.

Configuration
REQ-025 With macro DIGIT_SERIAL_ADDER_SUB_EN defined, the block SHALL add input port sub (1 bit), latched with the operands; sub=1 SHALL compute a + ~b + 1, ignoring cin, with cout = NOT borrow.
REQ-026 Without DIGIT_SERIAL_ADDER_SUB_EN, port sub SHALL NOT exist and the behaviour SHALL be pure addition per REQ-012.

Structure
REQ-027 Package dsa_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the constant DIGIT_W = 4.
REQ-028 The per-digit add SHALL be one instance of the team's 4-bit carry-lookahead cell CLA4bit (a, b, cin -> sum, cout); no other sub-module.

Verification
REQ-029 WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> out_valid 4 cycles after accept; sum=0x0000, cout=1.
REQ-030 WIDTH=16, a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; with out_ready held 0 for 5 cycles, sum and cout stay constant and out_valid stays 1.
REQ-031 rst pulsed in the 2nd RUN cycle -> IDLE next cycle, no out_valid; the next operation a=0x0F0F, b=0x00F1, cin=0 yields sum=0x1000.
REQ-032 in_valid held high with changing a/b during RUN -> result reflects only the operands latched at accept; in_ready is 0 throughout RUN and DONE.
REQ-033 WIDTH=4, a=0x9, b=0x8, cin=1 -> out_valid 1 cycle after accept; sum=0x2, cout=1.
REQ-034 With DIGIT_SERIAL_ADDER_SUB_EN, WIDTH=16, a=5, b=7, sub=1 -> sum=0xFFFE, cout=0; a=7, b=5, sub=1 -> sum=0x0002, cout=1.
